fc_result_argmax: RTL and testbench

Result-collection end of the LeNet inference pipeline: waits for the fully-connected stage's `fc_1_finish`, reads the NUM_CLASSES FC output scores from the result RAM through a synchronous 1-cycle-latency read port, and computes the signed argmax. It presents the winning class index to the downstream consumer (host/UART/LED logic) with a valid/ready handshake. It sits beside `layer4_top` as the consumer of its completion signal and output buffer.

---
 rtl/fc_result_argmax.sv | 161 ++++++++++++++++
 tb/tb_fc_result_argmax.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_argmax.sv
// fc_result_argmax: collects the FC output scores from the result RAM after
// fc_1_finish rises and reports the signed argmax over a valid/ready handshake.
// Optional feature: define FC_RESULT_SCORE_EN to drive the winning score on
// class_score; otherwise class_score is tied to zero.
module fc_result_argmax #(
   parameter int unsigned DATA_SIZE   = 16,
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned ADDR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fc_1_finish,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_SIZE-1:0]  rd_data,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [ADDR_WIDTH-1:0] class_idx,
   output logic [DATA_SIZE-1:0]  class_score,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic                         fin_q;
   logic                         start;
   logic                         smp_vld;
   logic [ADDR_WIDTH-1:0]        smp_idx;
   logic signed [DATA_SIZE-1:0]  max_val;
   logic signed [DATA_SIZE-1:0]  max_val_nxt;
   logic [ADDR_WIDTH-1:0]        max_idx;
   logic [ADDR_WIDTH-1:0]        max_idx_nxt;
   logic                         take_new;
   logic                         rd_en_nxt;
   logic [ADDR_WIDTH-1:0]        rd_addr_nxt;
   logic                         valid_nxt;

   // Rising edge of the FC completion level starts a collection
   assign start = fc_1_finish & ~fin_q;

   // Running signed maximum; address 0 seeds it, ties keep the lower index
   always_comb begin
      take_new    = 1'b0;
      max_val_nxt = max_val;
      max_idx_nxt = max_idx;
      if (smp_vld) begin
         if (smp_idx == '0) begin
            take_new = 1'b1;
         end else if ($signed(rd_data) > max_val) begin
            take_new = 1'b1;
         end
      end
      if (take_new) begin
         max_val_nxt = $signed(rd_data);
         max_idx_nxt = smp_idx;
      end
   end

   // Next-state and next-output logic for the collection sequencer
   always_comb begin
      state_nxt   = state;
      rd_en_nxt   = 1'b0;
      rd_addr_nxt = rd_addr;
      valid_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_READ;
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = '0;
            end
         end
         S_READ: begin
            if (rd_addr == LAST_ADDR) begin
               state_nxt = S_DRAIN;
            end else begin
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            state_nxt = S_HOLD;
            valid_nxt = 1'b1;
         end
         S_HOLD: begin
            if (result_ready) begin
               state_nxt = S_IDLE;
            end else begin
               valid_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered outputs, read-data pipeline tags and compare registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fin_q        <= 1'b0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         smp_vld      <= 1'b0;
         smp_idx      <= '0;
         max_val      <= '0;
         max_idx      <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         class_idx    <= '0;
      end else begin
         fin_q        <= fc_1_finish;
         rd_en        <= rd_en_nxt;
         rd_addr      <= rd_addr_nxt;
         smp_vld      <= rd_en;
         smp_idx      <= rd_addr;
         max_val      <= max_val_nxt;
         max_idx      <= max_idx_nxt;
         result_valid <= valid_nxt;
         busy         <= (state_nxt != S_IDLE);
         overrun      <= start & (state != S_IDLE);
         if (state == S_DRAIN) begin
            class_idx <= max_idx_nxt;
         end
      end
   end

`ifdef FC_RESULT_SCORE_EN
   // Winning score captured together with class_idx
   always_ff @(posedge clk) begin
      if (rst) begin
         class_score <= '0;
      end else if (state == S_DRAIN) begin
         class_score <= max_val_nxt;
      end
   end
`else
   assign class_score = '0;
`endif

endmodule

// File: tb/tb_fc_result_argmax.sv
// tb_fc_result_argmax: randomized scoreboard bench for fc_result_argmax.
module tb_fc_result_argmax;

   localparam int unsigned DS = 16;
   localparam int unsigned NC = 10;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          fc_1_finish;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DS-1:0] rd_data = '0;
   logic          result_valid;
   logic          result_ready;
   logic [AW-1:0] class_idx;
   logic [DS-1:0] class_score;
   logic          busy;
   logic          overrun;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [DS-1:0] score;
   } exp_t;

   logic signed [DS-1:0] ram [16];
   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   ov_seen     = 0;

   fc_result_argmax #(.DATA_SIZE(DS), .NUM_CLASSES(NC), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .fc_1_finish  (fc_1_finish),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .class_idx    (class_idx),
      .class_score  (class_score),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Result RAM: one-cycle read latency
   always @(posedge clk) begin
      if (rd_en) rd_data <= ram[rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: first index holding the largest signed score
   task automatic push_expect();
      exp_t e;
      int   best = 0;
      for (int i = 1; i < int'(NC); i++) begin
         if (ram[i] > ram[best]) best = i;
      end
      e.idx = AW'(best);
`ifdef FC_RESULT_SCORE_EN
      e.score = ram[best];
`else
      e.score = '0;
`endif
      sb_q.push_back(e);
   endtask

   task automatic fill_random(input bit narrow);
      for (int i = 0; i < int'(NC); i++) begin
         if (narrow) ram[i] = DS'(int'($urandom_range(0, 6)) - 3);
         else        ram[i] = DS'($urandom);
      end
   endtask

   // Monitor: compares every presented result against the scoreboard head
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result_valid", 32'(result_valid), 32'd0);
         end else begin
            check("class_idx", 32'(class_idx), 32'(sb_q[0].idx));
            check("class_score", 32'(class_score), 32'(sb_q[0].score));
            if (result_ready) void'(sb_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (overrun === 1'b1) ov_seen++;
   end

   // Called in cycle 0 (start already driven); checks read timing up to valid
   task automatic read_phase(input int ovr_cycle, input bit keep_fin);
      for (int k = 1; k <= int'(NC); k++) begin
         step();
         check("rd_en", 32'(rd_en), 32'd1);
         check("rd_addr", 32'(rd_addr), 32'(k - 1));
         check("busy_read", 32'(busy), 32'd1);
         if (k == 1 && !keep_fin) fc_1_finish = 1'b0;
         if (k == ovr_cycle) fc_1_finish = 1'b1;
         result_ready = 1'($urandom_range(0, 1));
      end
      step();
      check("rd_en_drain", 32'(rd_en), 32'd0);
      check("valid_early", 32'(result_valid), 32'd0);
      result_ready = 1'b0;
      step();
      check("valid_cycle", 32'(result_valid), 32'd1);
   endtask

   task automatic handshake(input int hold);
      for (int h = 0; h < hold; h++) begin
         step();
         check("valid_held", 32'(result_valid), 32'd1);
      end
      result_ready = 1'b1;
      step();
      check("valid_cleared", 32'(result_valid), 32'd0);
      check("busy_cleared", 32'(busy), 32'd0);
      result_ready = 1'b0;
   endtask

   task automatic run_one(input int hold, input int ovr_cycle);
      fc_1_finish = 1'b0;
      step();
      push_expect();
      fc_1_finish = 1'b1;
      read_phase(ovr_cycle, 1'b0);
      handshake(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ov0;
      rst = 1'b1;
      fc_1_finish = 1'b0;
      result_ready = 1'b0;
      for (int i = 0; i < 16; i++) ram[i] = '0;
      repeat (3) step();
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_class_idx", 32'(class_idx), 32'd0);
      check("rst_class_score", 32'(class_score), 32'd0);
      rst = 1'b0;
      step();

      // Directed: mixed scores, then all-negative with tie and most-negative value
      ram[0] = 3;    ram[1] = -7;  ram[2] = 12;  ram[3] = 5;  ram[4] = 0;
      ram[5] = -1;   ram[6] = 9;   ram[7] = 11;  ram[8] = 2;  ram[9] = 4;
      run_one(0, 0);
      ram[0] = -100; ram[1] = -3;  ram[2] = -50; ram[3] = -3; ram[4] = -9;
      ram[5] = DS'(16'h8000);      ram[6] = -1000; ram[7] = -7; ram[8] = -20; ram[9] = -200;
      run_one(0, 0);

      // Consumer stalls 20 cycles
      ram[0] = 3;    ram[1] = -7;  ram[2] = 12;  ram[3] = 5;  ram[4] = 0;
      ram[5] = -1;   ram[6] = 9;   ram[7] = 11;  ram[8] = 2;  ram[9] = 4;
      run_one(20, 0);

      // Second finish edge mid-collection
      fill_random(1'b0);
      ov0 = ov_seen;
      run_one(0, 5);
      repeat (5) begin
         step();
         check("no_second_collection", 32'(busy), 32'd0);
      end
      check("overrun_pulses", 32'(ov_seen - ov0), 32'd1);

      // Reset in cycle 6 of a collection
      fc_1_finish = 1'b0;
      step();
      fill_random(1'b0);
      fc_1_finish = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check("pre_rst_rd_en", 32'(rd_en), 32'd1);
         if (k == 1) fc_1_finish = 1'b0;
      end
      rst = 1'b1;
      step();
      check("rst_mid_rd_en", 32'(rd_en), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (15) begin
         step();
         check("abandoned_valid", 32'(result_valid), 32'd0);
      end
      fill_random(1'b1);
      run_one(0, 0);

      // finish level held high through reset release: exactly one collection
      ov0 = ov_seen;
      rst = 1'b1;
      fc_1_finish = 1'b1;
      repeat (2) step();
      check("rst_level_busy", 32'(busy), 32'd0);
      fill_random(1'b1);
      push_expect();
      rst = 1'b0;
      read_phase(0, 1'b1);
      handshake(0);
      repeat (20) begin
         step();
         check("level_no_repeat", 32'(busy), 32'd0);
      end
      check("level_no_overrun", 32'(ov_seen - ov0), 32'd0);

      // Randomized collections
      for (int r = 0; r < 12; r++) begin
         fill_random(1'($urandom_range(0, 1)));
         run_one(int'($urandom_range(0, 4)), 0);
      end

      step();
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
